seq_decoder: RTL and testbench

- Parametrised, registered successor to the combinational N-to-2^N enable decoder.
- One-hot output Y is driven from an internal index register, loaded directly from S (direct mode) or stepped by a prescaled counter (scan mode).
- Used for row/digit strobing and chip-select sequencing in the same datapaths as the combinational decoder.

---
 rtl/seq_decoder_pkg.sv | 32 +++
 rtl/seq_decoder_presc.sv | 56 +++++
 rtl/seq_decoder.sv | 108 ++++++++++
 tb/tb_seq_decoder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_decoder_pkg.sv
// -----------------------------------------------------------------------------
// seq_decoder_pkg
//   Shared definitions for the registered sequencing decoder.
//   - MODE_DIRECT / MODE_SCAN : encodings of the MODE input.
//   - MAX_SEL_W               : widest select the decoder supports.
//   - onehot()                : index -> one-hot vector at the maximum width;
//                               callers truncate to their own 2**SEL_W width.
//   - presc_width()           : counter width needed for a given scan divider.
// -----------------------------------------------------------------------------
package seq_decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int MAX_SEL_W = 6;
  localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

  // Decodes at the widest supported size so a single function serves every
  // SEL_W; the instantiating module casts the result down to 2**SEL_W bits.
  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
    logic [MAX_OUT_W-1:0] vec;
    vec = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // A divider of 1 still needs a one-bit counter so the port widths stay legal.
  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/seq_decoder_presc.sv
// -----------------------------------------------------------------------------
// seq_decoder_presc
//   Scan-step prescaler. Counts 0 .. SCAN_DIV-1 while running and pulses tick
//   on the last count, wrapping back to 0 on the same edge.
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset (counter -> 0)
//   clr   in   synchronous clear; dominates run, suppresses tick
//   run   in   count enable; when low the counter is held at 0
//   tick  out  combinational: high in the cycle whose edge performs a step
// -----------------------------------------------------------------------------
module seq_decoder_presc
  import seq_decoder_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int                CNT_W = presc_width(SCAN_DIV);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == LAST);
  assign tick    = run & ~clr & at_last;

  // Anything other than an uninterrupted run parks the counter at 0, so the
  // first step after entering scan mode is always a full SCAN_DIV away.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !run) begin
      cnt_d = '0;
    end else if (at_last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_decoder.sv
// -----------------------------------------------------------------------------
// seq_decoder
//   Registered N-to-2^N one-hot decoder with a direct mode (Y follows a loaded
//   index) and a scan mode (index steps every SCAN_DIV cycles, wrapping).
//
// Parameters
//   SEL_W     select width, 1..6; Y is 2**SEL_W bits
//   SCAN_DIV  clock cycles per scan step, >= 1
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   E     in   enable; low clears Y (and WRAP, prescaler) on the next edge
//   MODE  in   0 = direct, 1 = scan
//   LD    in   load strobe; S is sampled when high (ignored while E=0)
//   S     in   select / scan start index
//   Y     out  registered one-hot (or all-zero) output
//   IDX   out  current index register
//   WRAP  out  one-cycle pulse on the scan step from 2**SEL_W-1 to 0
//
// Update priority on each edge: rst, E=0, LD, scan step.
// -----------------------------------------------------------------------------
module seq_decoder
  import seq_decoder_pkg::*;
#(
  parameter int SEL_W    = 3,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  E,
  input  logic                  MODE,
  input  logic                  LD,
  input  logic [SEL_W-1:0]      S,
  output logic [2**SEL_W-1:0]   Y,
  output logic [SEL_W-1:0]      IDX,
  output logic                  WRAP
);

  localparam int OUT_W = 2 ** SEL_W;

  logic [SEL_W-1:0] idx_q;
  logic [SEL_W-1:0] idx_d;
  logic [OUT_W-1:0] y_q;
  logic [OUT_W-1:0] y_d;
  logic             wrap_q;
  logic             wrap_d;

  logic             presc_clr;
  logic             presc_run;
  logic             step;
  logic [SEL_W-1:0] idx_inc;

  // The prescaler only advances on an enabled, non-loading scan cycle; both a
  // load and a disable restart the count from 0.
  assign presc_clr = ~E | LD;
  assign presc_run = (MODE == MODE_SCAN);

  seq_decoder_presc #(
    .SCAN_DIV (SCAN_DIV)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .run  (presc_run),
    .tick (step)
  );

  // SEL_W-bit add, so stepping past the top index overflows naturally to 0.
  assign idx_inc = idx_q + SEL_W'(1);

  always_comb begin
    idx_d  = idx_q;
    y_d    = y_q;
    wrap_d = 1'b0;
    if (!E) begin
      y_d = '0;
    end else if (LD) begin
      idx_d = S;
      y_d   = OUT_W'(onehot(MAX_SEL_W'(S)));
    end else if (step) begin
      idx_d  = idx_inc;
      y_d    = OUT_W'(onehot(MAX_SEL_W'(idx_inc)));
      wrap_d = (idx_q == '1);
    end else begin
      // Direct mode and non-stepping scan cycles re-decode the held index,
      // which is what restores Y one cycle after E rises.
      y_d = OUT_W'(onehot(MAX_SEL_W'(idx_q)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      y_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      y_q    <= y_d;
      wrap_q <= wrap_d;
    end
  end

  assign Y    = y_q;
  assign IDX  = idx_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_seq_decoder.sv
// -----------------------------------------------------------------------------
// tb_seq_decoder
//   Three decoder instances sharing clk/rst:
//     dut_a : SEL_W=3, SCAN_DIV=4  (table of directed vectors, async reset)
//     dut_b : SEL_W=3, SCAN_DIV=1  (step-every-cycle walk)
//     dut_c : SEL_W=4, SCAN_DIV=4  (16-bit output, 15->0 wrap, async reset)
// -----------------------------------------------------------------------------
module tb_seq_decoder;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        a_e, a_mode, a_ld;
  logic [2:0]  a_s;
  logic [7:0]  a_y;
  logic [2:0]  a_idx;
  logic        a_wrap;

  logic        b_e, b_mode, b_ld;
  logic [2:0]  b_s;
  logic [7:0]  b_y;
  logic [2:0]  b_idx;
  logic        b_wrap;

  logic        c_e, c_mode, c_ld;
  logic [3:0]  c_s;
  logic [15:0] c_y;
  logic [3:0]  c_idx;
  logic        c_wrap;

  seq_decoder #(.SEL_W(3), .SCAN_DIV(4)) dut_a (
    .clk (clk), .rst (rst), .E (a_e), .MODE (a_mode), .LD (a_ld), .S (a_s),
    .Y (a_y), .IDX (a_idx), .WRAP (a_wrap)
  );

  seq_decoder #(.SEL_W(3), .SCAN_DIV(1)) dut_b (
    .clk (clk), .rst (rst), .E (b_e), .MODE (b_mode), .LD (b_ld), .S (b_s),
    .Y (b_y), .IDX (b_idx), .WRAP (b_wrap)
  );

  seq_decoder #(.SEL_W(4), .SCAN_DIV(4)) dut_c (
    .clk (clk), .rst (rst), .E (c_e), .MODE (c_mode), .LD (c_ld), .S (c_s),
    .Y (c_y), .IDX (c_idx), .WRAP (c_wrap)
  );

  // ---------------- scoreboard ----------------
  int tests_run;
  int tests_failed;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one rising edge and settle 1 time unit past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic e, input logic m, input logic ld, input logic [2:0] s);
    a_e = e; a_mode = m; a_ld = ld; a_s = s;
  endtask

  // ---------------- vector table for dut_a ----------------
  typedef struct packed {
    logic       e;
    logic       mode;
    logic       ld;
    logic [2:0] s;
    logic [7:0] y;
    logic [2:0] idx;
    logic       wrap;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic e, input logic m, input logic ld, input logic [2:0] s,
                             input logic [7:0] y, input logic [2:0] idx, input logic w);
    vec_t r;
    r.e = e; r.mode = m; r.ld = ld; r.s = s; r.y = y; r.idx = idx; r.wrap = w;
    return r;
  endfunction

  task automatic fill_table();
    // direct mode: load 3, hold, S ignored without LD, load 5
    vecs.push_back(v(1, 0, 1, 3, 8'h08, 3, 0));
    vecs.push_back(v(1, 0, 0, 0, 8'h08, 3, 0));
    vecs.push_back(v(1, 0, 0, 7, 8'h08, 3, 0));
    vecs.push_back(v(1, 0, 1, 5, 8'h20, 5, 0));
    // E=0: Y clears, IDX held, LD ignored in both modes
    vecs.push_back(v(0, 0, 0, 0, 8'h00, 5, 0));
    vecs.push_back(v(0, 0, 1, 2, 8'h00, 5, 0));
    vecs.push_back(v(0, 1, 1, 1, 8'h00, 5, 0));
    // E rises: held index back on Y after one edge
    vecs.push_back(v(1, 0, 0, 0, 8'h20, 5, 0));
    // scan from 6: bit6, four edges to bit7, four more to bit0 with WRAP
    vecs.push_back(v(1, 1, 1, 6, 8'h40, 6, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(v(1, 1, 0, 0, 8'h40, 6, 0));
    vecs.push_back(v(1, 1, 0, 0, 8'h80, 7, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(v(1, 1, 0, 0, 8'h80, 7, 0));
    vecs.push_back(v(1, 1, 0, 0, 8'h01, 0, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(v(1, 1, 0, 0, 8'h01, 0, 0));
    vecs.push_back(v(1, 1, 0, 0, 8'h02, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(v(1, 1, 0, 0, 8'h02, 1, 0));
    vecs.push_back(v(1, 1, 0, 0, 8'h04, 2, 0));
    // prescaler mid-count at IDX=2, load 5: next step a full 4 edges later
    vecs.push_back(v(1, 1, 0, 0, 8'h04, 2, 0));
    vecs.push_back(v(1, 1, 1, 5, 8'h20, 5, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(v(1, 1, 0, 0, 8'h20, 5, 0));
    vecs.push_back(v(1, 1, 0, 0, 8'h40, 6, 0));
    // scan -> direct mid-count freezes IDX; direct -> scan steps 4 edges later
    vecs.push_back(v(1, 1, 0, 0, 8'h40, 6, 0));
    vecs.push_back(v(1, 0, 0, 0, 8'h40, 6, 0));
    vecs.push_back(v(1, 0, 0, 0, 8'h40, 6, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(v(1, 1, 0, 0, 8'h40, 6, 0));
    vecs.push_back(v(1, 1, 0, 0, 8'h80, 7, 0));
    // E=0 mid-count clears the prescaler: full 4 edges after E returns
    vecs.push_back(v(1, 1, 0, 0, 8'h80, 7, 0));
    vecs.push_back(v(0, 1, 0, 0, 8'h00, 7, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(v(1, 1, 0, 0, 8'h80, 7, 0));
    vecs.push_back(v(1, 1, 0, 0, 8'h01, 0, 1));
    vecs.push_back(v(1, 1, 0, 0, 8'h01, 0, 0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int exp_idx;
    int wrap_count;
    logic [63:0] one;

    tests_run    = 0;
    tests_failed = 0;
    one          = 64'd1;

    rst = 1'b1;
    drive_a(0, 0, 0, 0);
    b_e = 0; b_mode = 0; b_ld = 0; b_s = 0;
    c_e = 0; c_mode = 0; c_ld = 0; c_s = 0;

    // reset state
    #12;
    check("reset a_y", 64'(a_y), 0);
    check("reset a_idx", 64'(a_idx), 0);
    check("reset a_wrap", 64'(a_wrap), 0);
    check("reset c_y", 64'(c_y), 0);
    rst = 1'b0;
    step();
    check("post-reset idle a_y", 64'(a_y), 0);

    // table-driven vectors on dut_a
    fill_table();
    foreach (vecs[i]) begin
      drive_a(vecs[i].e, vecs[i].mode, vecs[i].ld, vecs[i].s);
      step();
      check($sformatf("vec%0d y", i), 64'(a_y), 64'(vecs[i].y));
      check($sformatf("vec%0d idx", i), 64'(a_idx), 64'(vecs[i].idx));
      check($sformatf("vec%0d wrap", i), 64'(a_wrap), 64'(vecs[i].wrap));
      check($sformatf("vec%0d onehot", i), 64'(a_y == 0 || $onehot(a_y)), 1);
    end

    // SCAN_DIV=1 walk on dut_b: one step per edge, WRAP every 8th
    b_e = 1; b_mode = 1; b_ld = 1; b_s = 0;
    step();
    check("walk load y", 64'(b_y), 64'h01);
    check("walk load idx", 64'(b_idx), 0);
    b_ld = 0;
    wrap_count = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_idx = k % 8;
      check($sformatf("walk%0d idx", k), 64'(b_idx), 64'(exp_idx));
      check($sformatf("walk%0d y", k), 64'(b_y), one << exp_idx);
      check($sformatf("walk%0d wrap", k), 64'(b_wrap), 64'(exp_idx == 0));
      if (b_wrap) wrap_count++;
    end
    check("walk wrap count", 64'(wrap_count), 2);

    // SEL_W=4 scan on dut_c: 14 -> 15 -> 0 with WRAP
    c_e = 1; c_mode = 1; c_ld = 1; c_s = 4'd14;
    step();
    check("c load y", 64'(c_y), 64'h4000);
    check("c load idx", 64'(c_idx), 14);
    c_ld = 0;
    repeat (3) step();
    check("c pre-step y", 64'(c_y), 64'h4000);
    step();
    check("c step15 idx", 64'(c_idx), 15);
    check("c step15 y", 64'(c_y), 64'h8000);
    check("c step15 wrap", 64'(c_wrap), 0);
    repeat (3) step();
    check("c pre-wrap wrap", 64'(c_wrap), 0);
    step();
    check("c wrap idx", 64'(c_idx), 0);
    check("c wrap y", 64'(c_y), 64'h0001);
    check("c wrap pulse", 64'(c_wrap), 1);
    step();
    check("c wrap drops", 64'(c_wrap), 0);
    step();

    // async reset between edges while dut_a and dut_c are scanning
    drive_a(1, 1, 0, 0);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("async rst a_y", 64'(a_y), 0);
    check("async rst a_idx", 64'(a_idx), 0);
    check("async rst c_y", 64'(c_y), 0);
    check("async rst c_idx", 64'(c_idx), 0);
    check("async rst c_wrap", 64'(c_wrap), 0);
    #2;
    rst = 1'b0;
    repeat (3) step();
    check("after rst a_y", 64'(a_y), 64'h01);
    check("after rst c_y", 64'(c_y), 64'h0001);
    check("after rst c_idx", 64'(c_idx), 0);
    step();
    check("after rst a step idx", 64'(a_idx), 1);
    check("after rst a step y", 64'(a_y), 64'h02);
    check("after rst c step idx", 64'(c_idx), 1);
    check("after rst c step y", 64'(c_y), 64'h0002);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
